// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end arbiter.
// Holds opcode encodings, the controller state encoding and the watchdog default.
package alu_pkg;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    localparam int WDOG_MAX_DEFAULT = 200;

    // Result reported to the requester when the ALU never answers.
    localparam logic [7:0] ABORT_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_A   = 3'd1,
        LOAD_B   = 3'd2,
        WAIT_END = 3'd3,
        RESP     = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: on a tie the requester not granted last time wins.
module rr_arbiter2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_grant,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = 1'b0;
        if (i_req0 && i_req1) begin
            o_grant = ~i_last;
        end else if (i_req1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: arbitrates, sequences the
// A/B operand load, waits for END under a watchdog and returns a done pulse.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WDOG_MAX = WDOG_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] b0,
    input  logic [7:0] b1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] result,
    output logic       err,
    output logic       alu_begin,
    output logic [1:0] alu_op_code,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    input  logic       alu_end
);

    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_MAX);

    arb_state_t r_state;
    arb_state_t w_nextState;

    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_winner;
    logic       r_lastGrant;
    logic [7:0] r_result;
    logic       r_err;
    logic [7:0] r_wdog;

    logic       w_grant;
    logic       w_grantValid;
    logic [7:0] w_wdogNext;
    logic       w_wdogExpired;

    rr_arbiter2 u_rrArbiter (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (r_lastGrant),
        .o_grant (w_grant),
        .o_valid (w_grantValid)
    );

    // The current WAIT_END cycle is the WDOG_MAX-th one when the incremented count hits the limit.
    assign w_wdogNext    = r_wdog + 8'd1;
    assign w_wdogExpired = (w_wdogNext == WDOG_LIMIT);

    assign result = r_result;
    assign err    = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_winner    <= 1'b0;
            r_lastGrant <= 1'b1;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_winner    <= w_grant;
                        r_lastGrant <= w_grant;
                        r_op        <= w_grant ? op1 : op0;
                        r_a         <= w_grant ? a1 : a0;
                        r_b         <= w_grant ? b1 : b0;
                    end
                end
                LOAD_B: begin
                    r_wdog <= '0;
                end
                WAIT_END: begin
                    r_wdog <= w_wdogNext;
                    // A real END beats a watchdog expiry landing in the same cycle.
                    if (alu_end) begin
                        r_result <= alu_outbus;
                    end else if (w_wdogExpired) begin
                        r_result <= ABORT_RESULT;
                        r_err    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        done0       = 1'b0;
        done1       = 1'b0;
        alu_begin   = 1'b0;
        alu_op_code = '0;
        alu_inbus   = '0;
        case (r_state)
            IDLE: begin
                if (w_grantValid) begin
                    w_nextState = LOAD_A;
                end
            end
            LOAD_A: begin
                alu_begin   = 1'b1;
                alu_op_code = r_op;
                alu_inbus   = r_a;
                w_nextState = LOAD_B;
            end
            LOAD_B: begin
                alu_op_code = r_op;
                alu_inbus   = r_b;
                w_nextState = WAIT_END;
            end
            WAIT_END: begin
                alu_op_code = r_op;
                alu_inbus   = r_b;
                if (alu_end || w_wdogExpired) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                alu_op_code = r_op;
                alu_inbus   = r_b;
                done0       = ~r_winner;
                done1       = r_winner;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WDOG_MAX, default 200, meaning the number of WAIT_END cycles without alu_end before abort.
REQ-002 The port list SHALL be exactly as follows (name, direction, width, meaning):
  clk  input  1  single clock, all state updates on the rising edge
  reset  input  1  synchronous, active-high
  req0, req1  input  1  requester 0/1 holds the request until its done pulse
  op0, op1  input  2  opcode (00 add, 01 sub, 10 mul, 11 div)
  a0, a1  input  8  operand A
  b0, b1  input  8  operand B
  done0, done1  output  1  one-cycle completion pulse per requester
  result  output  8  result of the last completed operation, valid while doneN=1
  err  output  1  sticky watchdog-abort flag
  alu_begin  output  1  drives the ALU BEGIN input
  alu_op_code  output  2  drives the ALU op_code input
  alu_inbus  output  8  drives the ALU inbus
  alu_outbus  input  8  ALU outbus
  alu_end  input  1  ALU END

Function
REQ-003 The FSM SHALL have exactly the states IDLE, LOAD_A, LOAD_B, WAIT_END and RESP.
REQ-004 In IDLE with any req high, the block SHALL pick a winner, latch its op/a/b plus the winner index, and go to LOAD_A next cycle; with no req it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: on req0=req1=1 the requester not granted last wins; a lone requester always wins; the last-grant pointer updates only on grant.
REQ-006 In LOAD_A (one cycle) the block SHALL drive alu_begin=1, alu_op_code=latched op and alu_inbus=latched A.
REQ-007 In LOAD_B (one cycle) the block SHALL drive alu_begin=0 and alu_inbus=latched B, holding alu_op_code.
REQ-008 In WAIT_END the block SHALL hold alu_inbus=B and alu_op_code, and on alu_end=1 capture alu_outbus into result and go to RESP.
REQ-009 In RESP (one cycle) the block SHALL assert done of the winner only, with result stable, then return to IDLE.
REQ-010 Outside LOAD_A, alu_begin SHALL be 0; in IDLE, alu_inbus and alu_op_code SHALL be 0.
REQ-011 The requester SHALL deassert req on the edge at which done is sampled; a req still high in the following IDLE SHALL be treated as a new request.
REQ-012 Changes on op/a/b/req after grant SHALL be ignored until the return to IDLE.
REQ-013 An 8-bit watchdog SHALL clear on entry to WAIT_END and increment each WAIT_END cycle; at WDOG_MAX without alu_end the block SHALL set err=1, load result=8'hFF, and go to RESP.
REQ-014 alu_end arriving in the same cycle the watchdog hits WDOG_MAX SHALL win: normal capture, err unchanged.
REQ-015 alu_end seen in any state other than WAIT_END SHALL be ignored.
REQ-016 Minimum latency from grant (IDLE with req) to done SHALL be 4 cycles, with alu_end asserted in the first WAIT_END cycle.

Reset
REQ-017 On reset=1 at a clock edge, the FSM SHALL go to IDLE, all outputs SHALL be 0 (including err and result), the watchdog SHALL be 0, and the last-grant pointer SHALL be 1 so req0 wins the first tie.
REQ-018 Reset mid-operation SHALL abort without any done pulse; the ALU SHALL be reset by the same reset.

Structure
REQ-019 A shared package alu_pkg SHALL hold the opcode constants (ADD, SUB, MUL, DIV), the FSM state encoding and the WDOG_MAX default.
REQ-020 Round-robin selection SHALL be a sub-module rr_arbiter2 (req0, req1, last pointer in -> grant index, grant valid), instanced once.

Verification
REQ-021 The bench SHALL cover these scenarios:
  - req0, op0=00, a0=3, b0=2 with the ALU model -> alu_begin high exactly 1 cycle with inbus=3, then inbus=2, done0 pulse with result=5, done1 never asserted.
  - req0 and req1 raised the same cycle after reset (op=10, 7*3 and op=01, 9-4) -> req0 served first (result=21), then req1 (result=5); the next tie is granted to req0.
  - req1 held continuously while req0 pulses -> grants alternate 1,0,1; no starvation.
  - ALU model never asserts END -> after 200 WAIT_END cycles err=1, done pulse with result=8'hFF; err stays 1 until reset.
  - reset asserted during WAIT_END -> next cycle all outputs 0, state IDLE, no done; a fresh request then completes normally.
  - a0 changed during LOAD_B -> alu_inbus and result reflect the latched value only.
